alu_rr_scheduler: RTL

//  Shares one combinational ALU_N_bits instance between two requesters using round-robin arbitration.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_rr_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_pkg;

  // Number of legal opcodes; anything at or above this is rejected.
  localparam int unsigned NUM_OPS = 10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_LSR  = 4'd5,
    ALU_LSL  = 4'd6,
    ALU_MOD  = 4'd7,
    ALU_PASS = 4'd8,
    ALU_DIV  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  // Opcode out of range, or a divide/modulo with a zero divisor.
  function automatic logic op_illegal(input logic [3:0] op, input logic b_is_zero,
                                      input int unsigned num_ops);
    logic [31:0] op_ext;
    op_ext = {28'd0, op};
    return (op_ext >= num_ops) ||
           (((op == ALU_MOD) || (op == ALU_DIV)) && b_is_zero);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. On a tie the requester that did not win last is picked.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pure combinational grant decode.
  always_comb begin
    gnt_valid = |valid;
    gnt_id    = 1'b0;
    unique case (valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU between two requesters. A request is latched in
// IDLE, presented to the ALU for one EXEC cycle, and the registered result is held in RESP
// until the consumer takes it.
module alu_rr_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned NUM_OPS = 10
) (
  input  logic         clk,
  input  logic         rst,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  // response channel
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  // shared ALU
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_v,
  input  logic         alu_c,
  input  logic         alu_n,
  input  logic         alu_z
);

  import alu_pkg::*;

  sched_state_t state_q, state_d;
  logic         last_grant_q, last_grant_d;
  // The ALU drive registers double as the latched request payload.
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_ctrl_q, alu_ctrl_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  alu_flags_t   rsp_flags_q, rsp_flags_d;
  logic         rsp_err_q, rsp_err_d;

  logic         gnt_valid;
  logic         gnt_id;
  logic         xfer;
  logic         exec_err;
  alu_flags_t   alu_flags;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Ready only in IDLE and only towards the granted requester.
  always_comb begin
    req0_ready = (state_q == IDLE) && gnt_valid && !gnt_id;
    req1_ready = (state_q == IDLE) && gnt_valid && gnt_id;
    xfer       = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  end

  // Error decode against the latched opcode and divisor.
  always_comb begin
    exec_err  = op_illegal(alu_ctrl_q, (alu_b_q == '0), NUM_OPS);
    alu_flags = '{v: alu_v, c: alu_c, n: alu_n, z: alu_z};
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d      = EXEC;
          last_grant_d = gnt_id;
          alu_a_d      = gnt_id ? req1_a : req0_a;
          alu_b_d      = gnt_id ? req1_b : req0_b;
          alu_ctrl_d   = gnt_id ? req1_op : req0_op;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        // last_grant holds the id of the request currently in flight.
        rsp_id_d    = last_grant_q;
        if (exec_err) begin
          rsp_result_d = '0;
          rsp_flags_d  = '0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_err_d    = 1'b0;
        end
        // ALU is idle (pass-a of zero) outside EXEC.
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_ctrl_d = ALU_PASS;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= ALU_PASS;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Output wiring.
  always_comb begin
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_ctrl   = alu_ctrl_q;
    rsp_valid  = rsp_valid_q;
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_flags  = rsp_flags_q;
    rsp_err    = rsp_err_q;
  end

endmodule
